// File: rtl/bomb_scheduler.sv
// Shared bomb-slot pool for two players: edge-detected drop requests, round-robin
// arbitration, tile snapping, and a per-slot FREE/ARMED/BLAST fuse machine timed in frames.
module bomb_scheduler #(
  parameter int MAX_BOMBS        = 4,
  parameter int BOMBS_PER_PLAYER = 2,
  parameter int FUSE_FRAMES      = 90,
  parameter int BLAST_FRAMES     = 15,
  parameter int TILE_SIZE        = 32,
  parameter int GRID_X0          = 16,
  parameter int GRID_Y0          = 48
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_startOfFrame,
  input  logic                         i_drop_bomb_p0,
  input  logic                         i_drop_bomb_p1,
  input  logic [10:0]                  i_p0_topLeftX,
  input  logic [10:0]                  i_p0_topLeftY,
  input  logic [10:0]                  i_p1_topLeftX,
  input  logic [10:0]                  i_p1_topLeftY,
  input  logic [$clog2(MAX_BOMBS)-1:0] i_slot_sel,
  output logic [10:0]                  o_sel_tileX,
  output logic [10:0]                  o_sel_tileY,
  output logic [MAX_BOMBS-1:0]         o_bomb_armed,
  output logic [MAX_BOMBS-1:0]         o_bomb_blast,
  output logic [MAX_BOMBS-1:0]         o_explode_mask,
  output logic                         o_grant_p0,
  output logic                         o_grant_p1,
  output logic                         o_reject_p0,
  output logic                         o_reject_p1
);

  localparam int SW   = $clog2(MAX_BOMBS);
  localparam int MAXF = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
  localparam int CTW  = $clog2(MAXF + 1);
  localparam int CW   = $clog2(BOMBS_PER_PLAYER + 1);
  localparam int TS   = $clog2(TILE_SIZE);
  localparam logic [10:0] GX   = 11'(GRID_X0);
  localparam logic [10:0] GY   = 11'(GRID_Y0);
  localparam logic [10:0] HALF = 11'(TILE_SIZE / 2);

  typedef enum logic [1:0] {S_FREE = 2'd0, S_ARMED = 2'd1, S_BLAST = 2'd2} slot_state_t;

  slot_state_t          r_state  [MAX_BOMBS];
  logic [CTW-1:0]       r_ctr    [MAX_BOMBS];
  logic                 r_owner  [MAX_BOMBS];
  logic [10:0]          r_tile_x [MAX_BOMBS];
  logic [10:0]          r_tile_y [MAX_BOMBS];
  logic [CW-1:0]        r_cnt0, r_cnt1;
  logic                 r_rr, r_key0, r_key1, r_pend0, r_pend1;
  logic                 r_grant0, r_grant1, r_reject0, r_reject1;
  logic [MAX_BOMBS-1:0] r_explode;

  slot_state_t          w_state  [MAX_BOMBS];
  logic [CTW-1:0]       w_ctr    [MAX_BOMBS];
  logic                 w_owner  [MAX_BOMBS];
  logic [10:0]          w_tile_x [MAX_BOMBS];
  logic [10:0]          w_tile_y [MAX_BOMBS];
  logic [CW-1:0]        w_cnt0, w_cnt1, w_free0, w_free1, w_cnt_sel;
  logic                 w_rr, w_pend0, w_pend1, w_edge0, w_edge1;
  logic                 w_decide, w_serve_p1, w_accept, w_any_free, w_conflict;
  logic [SW-1:0]        w_free_idx;
  logic [10:0]          w_req_x, w_req_y, w_vx, w_vy, w_new_x, w_new_y;
  logic signed [10:0]   w_colx, w_rowy;
  logic [MAX_BOMBS-1:0] w_explode;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < MAX_BOMBS; i++) begin
        r_state[i]  <= S_FREE;
        r_ctr[i]    <= '0;
        r_owner[i]  <= 1'b0;
        r_tile_x[i] <= GX;
        r_tile_y[i] <= GY;
      end
      r_cnt0    <= '0;
      r_cnt1    <= '0;
      r_rr      <= 1'b0;
      r_key0    <= 1'b0;
      r_key1    <= 1'b0;
      r_pend0   <= 1'b0;
      r_pend1   <= 1'b0;
      r_grant0  <= 1'b0;
      r_grant1  <= 1'b0;
      r_reject0 <= 1'b0;
      r_reject1 <= 1'b0;
      r_explode <= '0;
    end else begin
      r_state   <= w_state;
      r_ctr     <= w_ctr;
      r_owner   <= w_owner;
      r_tile_x  <= w_tile_x;
      r_tile_y  <= w_tile_y;
      r_cnt0    <= w_cnt0;
      r_cnt1    <= w_cnt1;
      r_rr      <= w_rr;
      r_key0    <= i_drop_bomb_p0;
      r_key1    <= i_drop_bomb_p1;
      r_pend0   <= w_pend0;
      r_pend1   <= w_pend1;
      r_grant0  <= w_accept & ~w_serve_p1;
      r_grant1  <= w_accept & w_serve_p1;
      r_reject0 <= w_decide & ~w_accept & ~w_serve_p1;
      r_reject1 <= w_decide & ~w_accept & w_serve_p1;
      r_explode <= w_explode;
    end
  end

  always_comb begin
    w_edge0    = i_drop_bomb_p0 & ~r_key0;
    w_edge1    = i_drop_bomb_p1 & ~r_key1;
    w_decide   = r_pend0 | r_pend1;
    w_serve_p1 = r_pend1 & (~r_pend0 | r_rr);

    // snap the served player's centre to the grid: floor((p - origin + half) / tile)
    w_req_x = w_serve_p1 ? i_p1_topLeftX : i_p0_topLeftX;
    w_req_y = w_serve_p1 ? i_p1_topLeftY : i_p0_topLeftY;
    w_vx    = w_req_x - GX + HALF;
    w_vy    = w_req_y - GY + HALF;
    w_colx  = $signed(w_vx) >>> TS;
    w_rowy  = $signed(w_vy) >>> TS;
    w_new_x = GX + (w_colx <<< TS);
    w_new_y = GY + (w_rowy <<< TS);

    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
      if (r_state[i] == S_FREE) begin
        w_any_free = 1'b1;
        w_free_idx = SW'(i);
      end
    end

    w_conflict = 1'b0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (r_state[i] != S_FREE && r_tile_x[i] == w_new_x && r_tile_y[i] == w_new_y)
        w_conflict = 1'b1;
    end

    w_cnt_sel = w_serve_p1 ? r_cnt1 : r_cnt0;
    w_accept  = w_decide & w_any_free & ~w_conflict & (w_cnt_sel != CW'(BOMBS_PER_PLAYER));

    w_state   = r_state;
    w_ctr     = r_ctr;
    w_owner   = r_owner;
    w_tile_x  = r_tile_x;
    w_tile_y  = r_tile_y;
    w_explode = '0;
    w_free0   = '0;
    w_free1   = '0;

    for (int i = 0; i < MAX_BOMBS; i++) begin
      case (r_state[i])
        S_ARMED: if (i_startOfFrame) begin
          if (r_ctr[i] == CTW'(1)) begin
            w_state[i]   = S_BLAST;
            w_ctr[i]     = CTW'(BLAST_FRAMES);
            w_explode[i] = 1'b1;
          end else begin
            w_ctr[i] = r_ctr[i] - CTW'(1);
          end
        end
        S_BLAST: if (i_startOfFrame) begin
          if (r_ctr[i] == CTW'(1)) begin
            w_state[i] = S_FREE;
            w_ctr[i]   = '0;
            if (r_owner[i]) w_free1 = w_free1 + CW'(1);
            else            w_free0 = w_free0 + CW'(1);
          end else begin
            w_ctr[i] = r_ctr[i] - CTW'(1);
          end
        end
        default: ;
      endcase
    end

    // the granted slot was FREE above, so the aging loop never touches it this clock
    if (w_accept) begin
      w_state[w_free_idx]  = S_ARMED;
      w_ctr[w_free_idx]    = CTW'(FUSE_FRAMES);
      w_owner[w_free_idx]  = w_serve_p1;
      w_tile_x[w_free_idx] = w_new_x;
      w_tile_y[w_free_idx] = w_new_y;
    end

    w_cnt0 = r_cnt0 - w_free0;
    w_cnt1 = r_cnt1 - w_free1;
    if (w_accept & ~w_serve_p1) w_cnt0 = w_cnt0 + CW'(1);
    if (w_accept &  w_serve_p1) w_cnt1 = w_cnt1 + CW'(1);

    w_pend0 = (r_pend0 & ~(w_decide & ~w_serve_p1)) | w_edge0;
    w_pend1 = (r_pend1 & ~(w_decide &  w_serve_p1)) | w_edge1;
    w_rr    = w_decide ? ~w_serve_p1 : r_rr;
  end

  always_comb begin
    o_bomb_armed = '0;
    o_bomb_blast = '0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      o_bomb_armed[i] = (r_state[i] == S_ARMED);
      o_bomb_blast[i] = (r_state[i] == S_BLAST);
    end
    o_sel_tileX = GX;
    o_sel_tileY = GY;
    if (int'(i_slot_sel) < MAX_BOMBS) begin
      o_sel_tileX = r_tile_x[i_slot_sel];
      o_sel_tileY = r_tile_y[i_slot_sel];
    end
  end

  assign o_explode_mask = r_explode;
  assign o_grant_p0     = r_grant0;
  assign o_grant_p1     = r_grant1;
  assign o_reject_p0    = r_reject0;
  assign o_reject_p1    = r_reject1;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Bench for bomb_scheduler: directed scenarios plus a randomized run, all checked
// against a frame-level behavioural model of the slot pool.
module tb_bomb_scheduler;
  localparam int NB = 4, BPP = 2, FUSE = 90, BLAST = 15, TS = 32, GX = 16, GY = 48;

  logic        clk = 1'b0;
  logic        rst, sof, k0, k1;
  logic [10:0] p0x, p0y, p1x, p1y, tx, ty;
  logic [1:0]  sel;
  logic [3:0]  armed, blast, expl;
  logic        g0, g1, r0, r1;
  logic [15:0] dvec, exp_v;

  always #5 clk = ~clk;

  bomb_scheduler dut (
    .i_clk(clk), .i_reset(rst), .i_startOfFrame(sof),
    .i_drop_bomb_p0(k0), .i_drop_bomb_p1(k1),
    .i_p0_topLeftX(p0x), .i_p0_topLeftY(p0y), .i_p1_topLeftX(p1x), .i_p1_topLeftY(p1y),
    .i_slot_sel(sel), .o_sel_tileX(tx), .o_sel_tileY(ty),
    .o_bomb_armed(armed), .o_bomb_blast(blast), .o_explode_mask(expl),
    .o_grant_p0(g0), .o_grant_p1(g1), .o_reject_p0(r0), .o_reject_p1(r1)
  );

  assign dvec = {g1, g0, r1, r0, expl, blast, armed};

  // model: slot state 0=free 1=armed 2=blast
  int       m_st[NB], m_ctr[NB], m_own[NB], m_tx[NB], m_ty[NB];
  int       m_cnt[2];
  int       m_rr;
  bit [1:0] m_pend, m_key, m_g, m_r;
  bit [3:0] m_ex;
  int       total = 0, bad = 0;

  function automatic int snap(int p, int g);
    int v, c;
    v = p - g + TS / 2;
    c = (v >= 0) ? v / TS : -((-v + TS - 1) / TS);
    return g + c * TS;
  endfunction

  function automatic logic [15:0] mvec();
    logic [3:0] a, b;
    for (int i = 0; i < NB; i++) begin
      a[i] = (m_st[i] == 1);
      b[i] = (m_st[i] == 2);
    end
    return {m_g[1], m_g[0], m_r[1], m_r[0], m_ex, b, a};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_st[i] = 0; m_ctr[i] = 0; m_own[i] = 0; m_tx[i] = GX; m_ty[i] = GY;
    end
    m_cnt[0] = 0; m_cnt[1] = 0; m_rr = 0;
    m_pend = 0; m_key = 0; m_g = 0; m_r = 0; m_ex = 0;
  endtask

  task automatic model_step();
    int p, fs, ntx, nty;
    bit ok;
    bit [1:0] keys;
    keys = {k1, k0};
    m_g = 0; m_r = 0; m_ex = 0; p = -1; fs = -1; ntx = 0; nty = 0;
    if (m_pend != 0) p = (m_pend == 2'b11) ? m_rr : (m_pend[0] ? 0 : 1);
    if (p >= 0) begin
      if (p == 0) begin ntx = snap(int'($signed(p0x)), GX); nty = snap(int'($signed(p0y)), GY); end
      else        begin ntx = snap(int'($signed(p1x)), GX); nty = snap(int'($signed(p1y)), GY); end
      for (int i = NB - 1; i >= 0; i--) if (m_st[i] == 0) fs = i;
      ok = (m_cnt[p] < BPP) && (fs >= 0);
      for (int i = 0; i < NB; i++) if (m_st[i] != 0 && m_tx[i] == ntx && m_ty[i] == nty) ok = 0;
      if (ok) m_g[p] = 1; else m_r[p] = 1;
      m_pend[p] = 0;
      m_rr = 1 - p;
    end
    if (sof) begin
      for (int i = 0; i < NB; i++) begin
        if (m_st[i] != 0) begin
          if (m_ctr[i] > 1) m_ctr[i]--;
          else if (m_st[i] == 1) begin m_st[i] = 2; m_ctr[i] = BLAST; m_ex[i] = 1; end
          else begin m_st[i] = 0; m_ctr[i] = 0; m_cnt[m_own[i]]--; end
        end
      end
    end
    if (p >= 0 && m_g[p]) begin
      m_st[fs] = 1; m_ctr[fs] = FUSE; m_own[fs] = p; m_tx[fs] = ntx; m_ty[fs] = nty;
      m_cnt[p]++;
    end
    for (int i = 0; i < 2; i++) begin
      if (keys[i] && !m_key[i]) m_pend[i] = 1;
      m_key[i] = keys[i];
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic press(bit a, bit b);
    k0 = a; k1 = b;
    step();
    k0 = 1'b0; k1 = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; sof = 0; k0 = 0; k1 = 0; sel = 0;
    p0x = 0; p0y = 0; p1x = 0; p1y = 0;
    #2;
    total++;
    if (dvec !== 16'h0000) begin bad++; $display("FAIL reset_outputs got=%h exp=0000", dvec); end
    total++;
    if (tx !== 11'd16 || ty !== 11'd48) begin bad++; $display("FAIL reset_tile got=%0d/%0d exp=16/48", tx, ty); end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_drop();
    p0x = 16; p0y = 48; sel = 0;
    k0 = 1;
    step();
    total++;
    if (dvec !== 16'h0000) begin bad++; $display("FAIL t1_no_early_grant got=%h exp=0000", dvec); end
    step();
    total++;
    if (dvec !== 16'h4001) begin bad++; $display("FAIL t1_grant got=%h exp=4001", dvec); end
    total++;
    if (tx !== 11'd16 || ty !== 11'd48) begin bad++; $display("FAIL t1_tile got=%0d/%0d exp=16/48", tx, ty); end
    step();
    total++;
    if (dvec !== 16'h0001) begin bad++; $display("FAIL t1_hold_no_repeat got=%h exp=0001", dvec); end
    k0 = 0;
  endtask

  task automatic test_fuse_blast();
    for (int n = 1; n <= FUSE; n++) begin
      sof = 1; step(); sof = 0;
      exp_v = mvec();
      total++;
      if (dvec !== exp_v) begin bad++; $display("FAIL t2_fuse_model n=%0d got=%h exp=%h", n, dvec, exp_v); end
      if (n == FUSE - 1) begin
        total++;
        if (dvec !== 16'h0001) begin bad++; $display("FAIL t2_still_armed got=%h exp=0001", dvec); end
      end
      if (n == FUSE) begin
        total++;
        if (dvec !== 16'h0110) begin bad++; $display("FAIL t2_explode got=%h exp=0110", dvec); end
      end
      step();
    end
    total++;
    if (dvec !== 16'h0010) begin bad++; $display("FAIL t2_explode_one_clk got=%h exp=0010", dvec); end
    for (int n = 1; n <= BLAST; n++) begin
      sof = 1; step(); sof = 0;
      if (n == BLAST - 1) begin
        total++;
        if (dvec !== 16'h0010) begin bad++; $display("FAIL t2_blast_hold got=%h exp=0010", dvec); end
      end
      step();
    end
    total++;
    if (dvec !== 16'h0000) begin bad++; $display("FAIL t2_freed got=%h exp=0000", dvec); end
    p0x = 16; p0y = 48; press(1, 0);
    total++;
    if (dvec !== 16'h4001) begin bad++; $display("FAIL t2_regrant_a got=%h exp=4001", dvec); end
    p0x = 80; press(1, 0);
    total++;
    if (dvec !== 16'h4003) begin bad++; $display("FAIL t2_regrant_b got=%h exp=4003", dvec); end
  endtask

  task automatic test_tie();
    do_reset();
    p0x = 16; p0y = 48; p1x = 80; p1y = 48; sel = 1;
    press(1, 1);
    total++;
    if (dvec !== 16'h4001) begin bad++; $display("FAIL t3_first_p0 got=%h exp=4001", dvec); end
    step();
    total++;
    if (dvec !== 16'h8003) begin bad++; $display("FAIL t3_second_p1 got=%h exp=8003", dvec); end
    total++;
    if (tx !== 11'd80 || ty !== 11'd48) begin bad++; $display("FAIL t3_slot1_tile got=%0d/%0d exp=80/48", tx, ty); end
    p0y = 112; p1y = 112;
    press(1, 1);
    exp_v = mvec();
    total++;
    if (dvec !== exp_v) begin bad++; $display("FAIL t3_tie2_first got=%h exp=%h", dvec, exp_v); end
    step();
    exp_v = mvec();
    total++;
    if (dvec !== exp_v) begin bad++; $display("FAIL t3_tie2_second got=%h exp=%h", dvec, exp_v); end
  endtask

  task automatic test_limits();
    do_reset();
    p0x = 16; p0y = 48; press(1, 0);
    p0x = 48; press(1, 0);
    total++;
    if (dvec !== 16'h4003) begin bad++; $display("FAIL t4_two_grants got=%h exp=4003", dvec); end
    p0x = 112; press(1, 0);
    total++;
    if (dvec !== 16'h1003) begin bad++; $display("FAIL t4_limit_reject got=%h exp=1003", dvec); end
    p1x = 20; p1y = 50; press(0, 1);
    total++;
    if (dvec !== 16'h2003) begin bad++; $display("FAIL t4_tile_reject got=%h exp=2003", dvec); end
  endtask

  task automatic test_full_pool();
    do_reset();
    p0y = 48; p1y = 48;
    p0x = 16;  press(1, 0);
    p0x = 48;  press(1, 0);
    p1x = 80;  press(0, 1);
    p1x = 112; press(0, 1);
    total++;
    if (dvec !== 16'h800F) begin bad++; $display("FAIL t5_pool_full got=%h exp=800F", dvec); end
    p1x = 144; press(0, 1);
    total++;
    if (dvec !== 16'h200F) begin bad++; $display("FAIL t5_full_reject got=%h exp=200F", dvec); end
    for (int n = 1; n <= FUSE; n++) begin
      sof = 1; step(); sof = 0;
      if (n == FUSE) begin
        total++;
        if (dvec !== 16'h0FF0) begin bad++; $display("FAIL t5_all_explode got=%h exp=0FF0", dvec); end
      end
      step();
    end
    for (int n = 1; n < BLAST; n++) begin
      sof = 1; step(); sof = 0; step();
    end
    p1x = 176;
    k1 = 1; step();
    k1 = 0; sof = 1; step(); sof = 0;
    total++;
    if (dvec !== 16'h2000) begin bad++; $display("FAIL t5_reject_on_free got=%h exp=2000", dvec); end
    press(0, 1);
    total++;
    if (dvec !== 16'h8001) begin bad++; $display("FAIL t5_grant_after_free got=%h exp=8001", dvec); end
    exp_v = mvec();
    total++;
    if (dvec !== exp_v) begin bad++; $display("FAIL t5_model got=%h exp=%h", dvec, exp_v); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    p0x = 16; p0y = 48; press(1, 0);
    p1x = 80; p1y = 48; press(0, 1);
    for (int n = 1; n <= FUSE; n++) begin
      sof = 1; step(); sof = 0; step();
    end
    p0y = 112; press(1, 0);
    exp_v = mvec();
    total++;
    if (dvec !== exp_v || dvec !== 16'h4034) begin bad++; $display("FAIL t6_pre_state got=%h exp=%h", dvec, exp_v); end
    @(negedge clk);
    rst = 1'b1; sel = 0;
    #1;
    total++;
    if (dvec !== 16'h0000) begin bad++; $display("FAIL t6_async_clear got=%h exp=0000", dvec); end
    total++;
    if (tx !== 11'd16 || ty !== 11'd48) begin bad++; $display("FAIL t6_tile_clear got=%0d/%0d exp=16/48", tx, ty); end
    model_reset();
    sof = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      sof = n[0]; step();
      total++;
      if (dvec !== 16'h0000) begin bad++; $display("FAIL t6_quiet n=%0d got=%h exp=0000", n, dvec); end
    end
    sof = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) k0 = ~k0;
      if ($urandom_range(0, 5) == 0) k1 = ~k1;
      if ($urandom_range(0, 7) == 0) begin p0x = 11'($urandom_range(0, 200)); p0y = 11'($urandom_range(0, 150)); end
      if ($urandom_range(0, 7) == 0) begin p1x = 11'($urandom_range(0, 200)); p1y = 11'($urandom_range(0, 150)); end
      sof = ($urandom_range(0, 1) == 1);
      sel = 2'($urandom_range(0, 3));
      step();
      exp_v = mvec();
      total++;
      if (dvec !== exp_v) begin bad++; $display("FAIL rnd_vec n=%0d got=%h exp=%h", n, dvec, exp_v); end
      total++;
      if (int'($signed(tx)) != m_tx[sel] || int'($signed(ty)) != m_ty[sel]) begin
        bad++;
        $display("FAIL rnd_tile n=%0d slot=%0d got=%0d/%0d exp=%0d/%0d", n, sel, $signed(tx), $signed(ty), m_tx[sel], m_ty[sel]);
      end
    end
    k0 = 0; k1 = 0; sof = 0;
  endtask

  initial begin
    test_reset();
    test_single_drop();
    test_fuse_blast();
    test_tie();
    test_limits();
    test_full_pool();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
